// File: rtl/clock_counter.sv
// clock_counter: 24-hour BCD time-of-day counter driven by a synchronized 1 Hz strobe.
// Optional top-of-hour chime enabled by defining CLOCK_CHIME_EN.
module clock_counter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  INIT_HOUR   = 8'h00,
   parameter logic [7:0]  INIT_MIN    = 8'h00
) (
   input  logic       CP,
   input  logic       CR,
   input  logic       CP_1Hz,
   input  logic       adj_en,
   input  logic       inc_hour,
   input  logic       inc_min,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       carry_day,
   output logic       chime_lo,
   output logic       chime_hi
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   tick_q;
   logic                   sync_out;

   logic [7:0] hour_n;
   logic [7:0] min_n;
   logic [7:0] sec_n;
   logic       carry_n;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Flops reset high so a level already high at release is not a tick.
   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         sync_q <= '1;
         edge_q <= 1'b1;
         tick_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], CP_1Hz};
         edge_q <= sync_out;
         tick_q <= sync_out & ~edge_q;
      end
   end

   function automatic logic [7:0] inc_mod60(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) begin
            return 8'h00;
         end
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc_mod24(input logic [7:0] v);
      if (v == 8'h23) begin
         return 8'h00;
      end
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   always_comb begin
      hour_n  = hour_bcd;
      min_n   = min_bcd;
      sec_n   = sec_bcd;
      carry_n = 1'b0;
      unique case (1'b1)
         adj_en: begin
            sec_n = 8'h00;
            if (inc_min) begin
               min_n = inc_mod60(min_bcd);
            end
            if (inc_hour) begin
               hour_n = inc_mod24(hour_bcd);
            end
         end
         (tick_q & ~adj_en): begin
            sec_n = inc_mod60(sec_bcd);
            if (sec_bcd == 8'h59) begin
               min_n = inc_mod60(min_bcd);
               if (min_bcd == 8'h59) begin
                  hour_n  = inc_mod24(hour_bcd);
                  carry_n = (hour_bcd == 8'h23);
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         hour_bcd  <= INIT_HOUR;
         min_bcd   <= INIT_MIN;
         sec_bcd   <= 8'h00;
         carry_day <= 1'b0;
      end else begin
         hour_bcd  <= hour_n;
         min_bcd   <= min_n;
         sec_bcd   <= sec_n;
         carry_day <= carry_n;
      end
   end

`ifdef CLOCK_CHIME_EN
   logic chime_lo_n;
   logic chime_hi_n;

   // Decoded from the next count so chimes move with sec_bcd.
   always_comb begin
      chime_lo_n = 1'b0;
      chime_hi_n = 1'b0;
      if (!adj_en && min_n == 8'h59) begin
         unique case (sec_n)
            8'h51, 8'h53, 8'h55, 8'h57: chime_lo_n = 1'b1;
            8'h59:                      chime_hi_n = 1'b1;
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         chime_lo <= 1'b0;
         chime_hi <= 1'b0;
      end else begin
         chime_lo <= chime_lo_n;
         chime_hi <= chime_hi_n;
      end
   end
`else
   assign chime_lo = 1'b0;
   assign chime_hi = 1'b0;
`endif

endmodule

// File: tb/tb_clock_counter.sv
// tb_clock_counter: scoreboard bench for clock_counter (INIT 23:59).
// Expected time kept as plain integers and converted to BCD.
module tb_clock_counter;

   logic       CP;
   logic       CR;
   logic       CP_1Hz;
   logic       adj_en;
   logic       inc_hour;
   logic       inc_min;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       carry_day;
   logic       chime_lo;
   logic       chime_hi;

`ifdef CLOCK_CHIME_EN
   localparam bit CHIME = 1'b1;
`else
   localparam bit CHIME = 1'b0;
`endif

   typedef struct {
      logic [7:0] h;
      logic [7:0] m;
      logic [7:0] s;
      logic       cd;
      logic       lo;
      logic       hi;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int h = 23;
   int m = 59;
   int s = 0;

   clock_counter #(
      .SYNC_STAGES(2),
      .INIT_HOUR  (8'h23),
      .INIT_MIN   (8'h59)
   ) dut (
      .CP       (CP),
      .CR       (CR),
      .CP_1Hz   (CP_1Hz),
      .adj_en   (adj_en),
      .inc_hour (inc_hour),
      .inc_min  (inc_min),
      .hour_bcd (hour_bcd),
      .min_bcd  (min_bcd),
      .sec_bcd  (sec_bcd),
      .carry_day(carry_day),
      .chime_lo (chime_lo),
      .chime_hi (chime_hi)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   function automatic logic legal(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic exp_t snap(input logic cd);
      exp_t e;
      logic odd;
      odd = (s == 51) || (s == 53) || (s == 55) || (s == 57);
      e.h  = bcd(h);
      e.m  = bcd(m);
      e.s  = bcd(s);
      e.cd = cd;
      e.lo = CHIME && !adj_en && (m == 59) && odd;
      e.hi = CHIME && !adj_en && (m == 59) && (s == 59);
      return e;
   endfunction

   task automatic compare_exp();
      exp_t e;
      if (q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         check("hour", 32'(hour_bcd), 32'(e.h));
         check("min", 32'(min_bcd), 32'(e.m));
         check("sec", 32'(sec_bcd), 32'(e.s));
         check("carry_day", 32'(carry_day), 32'(e.cd));
         check("chime_lo", 32'(chime_lo), 32'(e.lo));
         check("chime_hi", 32'(chime_hi), 32'(e.hi));
         check("bcd_legal",
               32'(legal(hour_bcd) && legal(min_bcd) && legal(sec_bcd)),
               32'd1);
      end
   endtask

   task automatic do_tick();
      logic [7:0] prev;
      bit seen;
      logic cd;
      @(negedge CP);
      CP_1Hz = 1'b0;
      repeat (4) @(negedge CP);
      CP_1Hz = 1'b1;
      cd = (h == 23) && (m == 59) && (s == 59);
      s++;
      if (s == 60) begin
         s = 0;
         m++;
         if (m == 60) begin
            m = 0;
            h = (h + 1) % 24;
         end
      end
      q.push_back(snap(cd));
      prev = sec_bcd;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CP);
         if (sec_bcd !== prev) seen = 1;
      end
      if (!seen) begin
         check("tick_timeout", 32'd0, 32'd1);
         void'(q.pop_front());
      end else begin
         compare_exp();
         @(negedge CP);
         check("carry_one_cycle", 32'(carry_day), 32'd0);
      end
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic tick_ignored();
      @(negedge CP);
      CP_1Hz = 1'b0;
      repeat (4) @(negedge CP);
      CP_1Hz = 1'b1;
      repeat (20) @(negedge CP);
      check("adj_tick_h", 32'(hour_bcd), 32'(bcd(h)));
      check("adj_tick_m", 32'(min_bcd), 32'(bcd(m)));
      check("adj_tick_s", 32'(sec_bcd), 32'(bcd(s)));
   endtask

   task automatic set_adj(input logic v);
      @(negedge CP);
      adj_en = v;
      if (v) s = 0;
      q.push_back(snap(1'b0));
      @(negedge CP);
      compare_exp();
   endtask

   task automatic inc_n(input logic ih, input logic im, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CP);
         inc_hour = ih;
         inc_min  = im;
         if (adj_en) begin
            s = 0;
            if (im) m = (m + 1) % 60;
            if (ih) h = (h + 1) % 24;
         end
         q.push_back(snap(1'b0));
         @(negedge CP);
         compare_exp();
         inc_hour = 1'b0;
         inc_min  = 1'b0;
      end
   endtask

   initial begin
      int changes;
      logic [7:0] prev;
      CR       = 1'b1;
      CP_1Hz   = 1'b1;
      adj_en   = 1'b0;
      inc_hour = 1'b0;
      inc_min  = 1'b0;
      repeat (3) @(negedge CP);
      q.push_back(snap(1'b0));
      compare_exp();
      CR = 1'b0;

      // CP_1Hz high through reset release: no tick expected.
      changes = 0;
      prev = sec_bcd;
      repeat (1000) begin
         @(negedge CP);
         if (sec_bcd !== prev) changes++;
      end
      check("no_tick_high", 32'(changes), 32'd0);

      // 23:59:00 -> 23:59:59 -> 00:00:00 with day carry.
      run_ticks(59);
      check("at_235959", 32'({hour_bcd, min_bcd, sec_bcd}),
            32'h235959);
      run_ticks(1);

      // 09:59:59 -> 10:00:00
      set_adj(1'b1);
      inc_n(1'b1, 1'b0, 9);
      inc_n(1'b0, 1'b1, 59);
      set_adj(1'b0);
      run_ticks(60);
      check("at_100000", 32'({hour_bcd, min_bcd, sec_bcd}),
            32'h100000);

      // Increments ignored outside set mode.
      inc_n(1'b1, 1'b0, 1);
      inc_n(1'b0, 1'b1, 1);

      // 19:59:59 -> 20:00:00
      set_adj(1'b1);
      inc_n(1'b1, 1'b0, 9);
      inc_n(1'b0, 1'b1, 59);
      set_adj(1'b0);
      run_ticks(60);
      check("at_200000", 32'({hour_bcd, min_bcd, sec_bcd}),
            32'h200000);

      // Chime window 10:59:50 .. 11:00:00
      set_adj(1'b1);
      inc_n(1'b1, 1'b0, 14);
      inc_n(1'b0, 1'b1, 59);
      set_adj(1'b0);
      run_ticks(60);
      check("chime_lo_off", 32'(chime_lo), 32'd0);
      check("chime_hi_off", 32'(chime_hi), 32'd0);

      // Set mode at 12:34:56.
      set_adj(1'b1);
      inc_n(1'b1, 1'b0, 1);
      inc_n(1'b0, 1'b1, 34);
      set_adj(1'b0);
      run_ticks(56);
      check("at_123456", 32'({hour_bcd, min_bcd, sec_bcd}),
            32'h123456);
      set_adj(1'b1);
      inc_n(1'b0, 1'b1, 30);
      check("at_1204", 32'({hour_bcd, min_bcd}), 32'h1204);
      tick_ignored();
      tick_ignored();
      inc_n(1'b1, 1'b0, 11);
      inc_n(1'b0, 1'b1, 55);
      inc_n(1'b1, 1'b1, 1);
      check("both_inc", 32'({hour_bcd, min_bcd}), 32'h0000);
      set_adj(1'b0);

      // Async reset at 05:06:07.
      set_adj(1'b1);
      inc_n(1'b1, 1'b0, 5);
      inc_n(1'b0, 1'b1, 6);
      set_adj(1'b0);
      run_ticks(7);
      check("at_050607", 32'({hour_bcd, min_bcd, sec_bcd}),
            32'h050607);
      @(posedge CP);
      #2;
      CR = 1'b1;
      #1;
      h = 23;
      m = 59;
      s = 0;
      q.push_back(snap(1'b0));
      compare_exp();
      @(negedge CP);
      CR = 1'b0;
      run_ticks(2);

      check("sb_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
